// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the FP adder arbiter and its helpers.
package fp_add_arbiter_pkg;

  localparam int unsigned DATALENGTH = 32;

  localparam logic [DATALENGTH-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [DATALENGTH-1:0] FP32_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_A  = 3'd1,
    ST_DROP_A  = 3'd2,
    ST_SEND_B  = 3'd3,
    ST_DROP_B  = 3'd4,
    ST_WAIT_Z  = 3'd5,
    ST_RESPOND = 3'd6
  } arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            found_o
);

  localparam int unsigned SW = IDXW + 1;

  logic [NREQ-1:0] rot;
  logic [SW-1:0]   sum;

  // Rotate so bit 0 is the requester at ptr.
  assign rot = NREQ'({req_i, req_i} >> ptr_i);

  // Scan from the highest offset down so the lowest offset wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = SW'(ptr_i) + SW'(k);
        if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
        idx_o   = sum[IDXW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one strobe/ack FP32 adder between NREQ requesters.
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = DATALENGTH,
  parameter int unsigned IDXW  = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] op_a_i,
  input  logic [NREQ*WIDTH-1:0] op_b_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [WIDTH-1:0]      result_o,
  output logic [NREQ-1:0]       result_valid_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      add_a_o,
  output logic [WIDTH-1:0]      add_b_o,
  output logic                  add_a_stb_o,
  output logic                  add_b_stb_o,
  output logic                  add_z_ack_o,
  input  logic [WIDTH-1:0]      add_z_i,
  input  logic                  add_z_stb_i,
  input  logic                  add_a_ack_i,
  input  logic                  add_b_ack_i
);

  arb_state_e       state_q;
  logic [IDXW-1:0]  ptr_q, ptr_d, sel_q, pick_idx;
  logic             pick_found;
  logic [NREQ-1:0]  grant_q, grant_d, rv_q;
  logic [WIDTH-1:0] result_q, add_a_q, add_b_q;
  logic             busy_q, a_stb_q, b_stb_q, z_ack_q;
  logic [WIDTH-1:0] op_a_arr [NREQ];
  logic [WIDTH-1:0] op_b_arr [NREQ];

  // Split the flattened operand buses into per-requester words.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a_arr[g] = op_a_i[g*WIDTH +: WIDTH];
    assign op_b_arr[g] = op_b_i[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign grant_d = NREQ'(1) << pick_idx;
  assign ptr_d   = (sel_q == IDXW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

  // Arbitration and adder handshake sequencing; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      rv_q     <= '0;
      result_q <= FP32_ZERO;
      add_a_q  <= FP32_ZERO;
      add_b_q  <= FP32_ZERO;
      busy_q   <= 1'b0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      z_ack_q  <= 1'b0;
    end else begin
      rv_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            add_a_q <= op_a_arr[pick_idx];
            add_b_q <= op_b_arr[pick_idx];
            sel_q   <= pick_idx;
            grant_q <= grant_d;
            busy_q  <= 1'b1;
            state_q <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (add_a_ack_i) begin
            a_stb_q <= 1'b1;
            state_q <= ST_DROP_A;
          end
        end
        ST_DROP_A: begin
          if (!add_a_ack_i) begin
            a_stb_q <= 1'b0;
            state_q <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (add_b_ack_i) begin
            b_stb_q <= 1'b1;
            state_q <= ST_DROP_B;
          end
        end
        ST_DROP_B: begin
          if (!add_b_ack_i) begin
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b1;
            state_q <= ST_WAIT_Z;
          end
        end
        ST_WAIT_Z: begin
          if (add_z_stb_i) begin
            result_q <= add_z_i;
            z_ack_q  <= 1'b0;
            state_q  <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          rv_q[sel_q] <= 1'b1;
          grant_q     <= '0;
          ptr_q       <= ptr_d;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign busy_o         = busy_q;
  assign add_a_o        = add_a_q;
  assign add_b_o        = add_b_q;
  assign add_a_stb_o    = a_stb_q;
  assign add_b_stb_o    = b_stb_q;
  assign add_z_ack_o    = z_ack_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural adder plus round-robin reference model.
module tb_fp_add_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] op_a = '0;
  logic [NREQ*WIDTH-1:0] op_b = '0;
  logic [NREQ-1:0]       grant_o, result_valid_o;
  logic [WIDTH-1:0]      result_o, add_a_o, add_b_o;
  logic                  busy_o, add_a_stb_o, add_b_stb_o, add_z_ack_o;
  logic [WIDTH-1:0]      add_z;
  logic                  add_z_stb, add_a_ack, add_b_ack;

  int checks = 0;
  int errors = 0;

  fp_add_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .grant_o        (grant_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .add_a_o        (add_a_o),
    .add_b_o        (add_b_o),
    .add_a_stb_o    (add_a_stb_o),
    .add_b_stb_o    (add_b_stb_o),
    .add_z_ack_o    (add_z_ack_o),
    .add_z_i        (add_z),
    .add_z_stb_i    (add_z_stb),
    .add_a_ack_i    (add_a_ack),
    .add_b_ack_i    (add_b_ack)
  );

  always #5 clk = ~clk;

  // FP32 <-> real conversion for normal numbers and zero.
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Behavioural strobe/ack adder sharing the reset.
  int          m_st, m_lat;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_lat <= 0; add_a_ack <= 1'b0; add_b_ack <= 1'b0;
      add_z_stb <= 1'b0; add_z <= '0; m_a <= '0; m_b <= '0;
    end else begin
      case (m_st)
        0: begin
          add_a_ack <= 1'b1;
          if (add_a_ack && add_a_stb_o) begin m_a <= add_a_o; add_a_ack <= 1'b0; m_st <= 1; end
        end
        1: begin
          add_b_ack <= 1'b1;
          if (add_b_ack && add_b_stb_o) begin
            m_b <= add_b_o; add_b_ack <= 1'b0; m_st <= 2; m_lat <= int'($urandom_range(0, 3));
          end
        end
        2: begin
          if (m_lat == 0) begin add_z <= r2fp(fp2r(m_a) + fp2r(m_b)); add_z_stb <= 1'b1; m_st <= 3; end
          else m_lat <= m_lat - 1;
        end
        default: begin
          if (add_z_stb && add_z_ack_o) begin add_z_stb <= 1'b0; m_st <= 0; end
        end
      endcase
    end
  end

  // Protocol watcher: strobes rise only on a seen ack, z ack only while waiting, no result without z.
  logic p_a_ack, p_b_ack, p_a_stb, p_b_stb, z_seen;
  int   hs_viol = 0;
  int   hs_events = 0;
  always @(negedge clk) begin : mon
    int v, e;
    v = 0; e = 0;
    if (rst) begin
      p_a_ack <= 1'b0; p_b_ack <= 1'b0; p_a_stb <= 1'b0; p_b_stb <= 1'b0; z_seen <= 1'b0;
    end else begin
      if (add_a_stb_o && !p_a_stb) begin e++; if (!p_a_ack) v++; end
      if (add_b_stb_o && !p_b_stb) begin e++; if (!p_b_ack) v++; end
      if (add_z_ack_o && (add_a_stb_o || add_b_stb_o || result_valid_o != '0 || grant_o == '0)) v++;
      if (result_valid_o != '0) begin e++; if (!z_seen) v++; z_seen <= 1'b0; end
      else if (add_z_stb && add_z_ack_o) z_seen <= 1'b1;
      p_a_ack <= add_a_ack; p_b_ack <= add_b_ack; p_a_stb <= add_a_stb_o; p_b_stb <= add_b_stb_o;
    end
    hs_viol <= hs_viol + v;
    hs_events <= hs_events + e;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rv(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (result_valid_o != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({grant_o, result_valid_o, busy_o} !== '0)
      begin errors++; $display("FAIL reset_ctrl got %h want 0", {grant_o, result_valid_o, busy_o}); end
    checks++; if ({result_o, add_a_o, add_b_o} !== '0)
      begin errors++; $display("FAIL reset_data got %h want 0", {result_o, add_a_o, add_b_o}); end
    checks++; if ({add_a_stb_o, add_b_stb_o, add_z_ack_o} !== 3'b000)
      begin errors++; $display("FAIL reset_hs got %b want 000", {add_a_stb_o, add_b_stb_o, add_z_ack_o}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({busy_o, grant_o, add_a_stb_o, add_b_stb_o, add_z_ack_o} !== '0)
      begin errors++; $display("FAIL idle_noreq got %h want 0", {busy_o, grant_o, add_a_stb_o, add_b_stb_o, add_z_ack_o}); end
  endtask

  task automatic test_single();
    logic ok;
    do_reset();
    op_a[0 +: 32] = 32'h3F80_0000; op_b[0 +: 32] = 32'h4000_0000; req = 4'b0001;
    @(negedge clk);
    checks++; if (grant_o !== 4'b0001 || busy_o !== 1'b1)
      begin errors++; $display("FAIL single_grant got %b/%b want 0001/1", grant_o, busy_o); end
    req = 4'b0000;
    wait_rv(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got none want rv"); end
    checks++; if (result_valid_o !== 4'b0001 || result_o !== 32'h4040_0000)
      begin errors++; $display("FAIL single_result got %b %h want 0001 40400000", result_valid_o, result_o); end
    @(negedge clk);
    checks++; if (result_valid_o !== 4'b0000 || busy_o !== 1'b0 || grant_o !== 4'b0000)
      begin errors++; $display("FAIL single_after got rv=%b busy=%b grant=%b want 0", result_valid_o, busy_o, grant_o); end
  endtask

  task automatic test_all_four();
    logic ok;
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    bv[0] = 32'h0000_0000; bv[1] = 32'h3F00_0000; bv[2] = 32'h3F80_0000; bv[3] = 32'h3FC0_0000;
    ev[0] = 32'h3F80_0000; ev[1] = 32'h3FC0_0000; ev[2] = 32'h4000_0000; ev[3] = 32'h4020_0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin op_a[i*32 +: 32] = 32'h3F80_0000; op_b[i*32 +: 32] = bv[i]; end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_rv(200, ok);
      checks++; if (!ok || result_valid_o !== 4'(1 << i) || result_o !== ev[i])
        begin errors++; $display("FAIL all4_%0d got rv=%b res=%h want %b %h", i, result_valid_o, result_o, 4'(1 << i), ev[i]); end
      req = req & ~result_valid_o;
    end
    req = '0;
  endtask

  task automatic test_fairness();
    logic ok;
    do_reset();
    op_a[0 +: 32] = 32'h3F80_0000; op_b[0 +: 32] = 32'h3F80_0000;
    op_a[64 +: 32] = 32'h4000_0000; op_b[64 +: 32] = 32'h4000_0000;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0101;
    wait_rv(200, ok);
    checks++; if (!ok || result_valid_o !== 4'b0001)
      begin errors++; $display("FAIL fair_first got %b want 0001", result_valid_o); end
    wait_rv(200, ok);
    checks++; if (!ok || result_valid_o !== 4'b0100 || result_o !== 32'h4080_0000)
      begin errors++; $display("FAIL fair_second got %b %h want 0100 40800000", result_valid_o, result_o); end
    req = 4'b0001;
    wait_rv(200, ok);
    checks++; if (!ok || result_valid_o !== 4'b0001)
      begin errors++; $display("FAIL fair_third got %b want 0001", result_valid_o); end
    req = '0;
  endtask

  task automatic test_operand_hold();
    logic ok;
    int c;
    do_reset();
    op_a[32 +: 32] = 32'h3F80_0000; op_b[32 +: 32] = 32'h3F80_0000; req = 4'b0010;
    c = 0;
    while (!add_b_ack && c < 100) begin @(negedge clk); c++; end
    op_a[32 +: 32] = 32'h4120_0000; req = '0;
    wait_rv(200, ok);
    checks++; if (!ok || result_valid_o !== 4'b0010 || result_o !== 32'h4000_0000)
      begin errors++; $display("FAIL hold_ops got %b %h want 0010 40000000", result_valid_o, result_o); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int c;
    do_reset();
    op_a[32 +: 32] = 32'h4000_0000; op_b[32 +: 32] = 32'h4000_0000; req = 4'b0010;
    c = 0;
    while (!add_z_ack_o && c < 100) begin @(negedge clk); c++; end
    checks++; if (!add_z_ack_o) begin errors++; $display("FAIL midrst_reach got zack=0 want 1"); end
    rst = 1'b1; req = '0;
    #1;
    checks++; if ({grant_o, result_valid_o, busy_o, add_a_stb_o, add_b_stb_o, add_z_ack_o, result_o, add_a_o, add_b_o} !== '0)
      begin errors++; $display("FAIL midrst_outs got grant=%b busy=%b zack=%b a=%h want 0", grant_o, busy_o, add_z_ack_o, add_a_o); end
    @(negedge clk); rst = 1'b0;
    op_a[96 +: 32] = 32'h3F80_0000; op_b[96 +: 32] = 32'h3F80_0000; req = 4'b1000;
    wait_rv(200, ok);
    checks++; if (!ok || result_valid_o !== 4'b1000 || result_o !== 32'h4000_0000)
      begin errors++; $display("FAIL midrst_after got %b %h want 1000 40000000", result_valid_o, result_o); end
    req = '0;
  endtask

  // Random levels and operands against a round-robin scoreboard.
  task automatic test_random();
    int ptr_m, sel_m, served, j;
    logic pending, found;
    logic [NREQ-1:0] prev_grant;
    logic [31:0] exp_a, exp_b, exp_res;
    do_reset();
    ptr_m = 0; sel_m = 0; served = 0; pending = 1'b0; prev_grant = '0;
    exp_a = '0; exp_b = '0; exp_res = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (grant_o != '0 && prev_grant == '0) begin
        found = 1'b0; j = 0;
        for (int k = 0; k < NREQ; k++)
          if (!found && req[(ptr_m + k) % NREQ]) begin found = 1'b1; j = (ptr_m + k) % NREQ; end
        exp_a = op_a[j*32 +: 32]; exp_b = op_b[j*32 +: 32];
        checks++; if (!found || grant_o !== 4'(1 << j))
          begin errors++; $display("FAIL rnd_grant got %b want %b (req %b ptr %0d)", grant_o, 4'(1 << j), req, ptr_m); end
        checks++; if (add_a_o !== exp_a || add_b_o !== exp_b)
          begin errors++; $display("FAIL rnd_ops got %h %h want %h %h", add_a_o, add_b_o, exp_a, exp_b); end
        sel_m = j; pending = 1'b1;
        exp_res = r2fp(fp2r(exp_a) + fp2r(exp_b));
      end
      if (result_valid_o != '0) begin
        checks++; if (!pending || result_valid_o !== 4'(1 << sel_m) || result_o !== exp_res)
          begin errors++; $display("FAIL rnd_result got %b %h want %b %h", result_valid_o, result_o, 4'(1 << sel_m), exp_res); end
        ptr_m = (sel_m + 1) % NREQ; pending = 1'b0; served++;
      end
      prev_grant = grant_o;
      if (served >= 30) begin
        req = '0;
        if (!busy_o && grant_o == '0) break;
      end else begin
        if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        for (int i = 0; i < NREQ; i++) begin
          op_a[i*32 +: 32] = r2fp(real'($urandom_range(0, 63)) * 0.5);
          op_b[i*32 +: 32] = r2fp(real'($urandom_range(0, 63)) * 0.5);
        end
      end
    end
    checks++; if (served < 30 || busy_o)
      begin errors++; $display("FAIL rnd_progress got %0d served busy=%b want 30 idle", served, busy_o); end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    checks++; if (hs_viol != 0) begin errors++; $display("FAIL handshake got %0d violations want 0", hs_viol); end
    checks++; if (hs_events < 40) begin errors++; $display("FAIL handshake_events got %0d want >=40", hs_events); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_operand_hold();
    test_reset_mid();
    test_random();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
